// File: rtl/roi_apb_master.sv
// APB write initiator that pushes packed ROI coordinate pairs to the ROI slave.
// Optional ACCESS wait-state timeout is built when ROI_APB_TIMEOUT_EN is defined.
module roi_apb_master #(
  parameter int APB_DATA_WIDTH = 64,
  parameter int COORD_WIDTH    = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [COORD_WIDTH-1:0]    req_xy_0_i,
  input  logic [COORD_WIDTH-1:0]    req_xy_1_i,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  output logic                      apb_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i,
  output logic                      done_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] data_q, data_d;
  logic                      timeout;

  if (APB_DATA_WIDTH != 2 * COORD_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("roi_apb_master: inconsistent parameters");
  end

`ifdef ROI_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts ACCESS wait states; cleared in SETUP so every transfer starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !apb_pready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (state_q == ACCESS) && !apb_pready_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next state and next values of every output register, so no input reaches an output combinationally.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        ready_d   = 1'b1;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (req_valid_i) begin
          state_d   = SETUP;
          ready_d   = 1'b0;
          psel_d    = 1'b1;
          addr_d    = req_addr_i;
          data_d    = {req_xy_1_i, req_xy_0_i};
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        ready_d   = 1'b0;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (apb_pready_i || timeout) begin
          state_d   = IDLE;
          ready_d   = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          err_d     = apb_pready_i ? apb_pslverr_i : 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        ready_d   = 1'b1;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = psel_q;
  assign apb_paddr_o   = addr_q;
  assign apb_pwdata_o  = data_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_roi_apb_master.sv
// Self-checking bench for roi_apb_master: cycle-accurate protocol checks plus a
// scoreboard of expected transfers. Timeout cases run when ROI_APB_TIMEOUT_EN is defined.
module tb_roi_apb_master;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic [31:0] req_xy_0_i;
  logic [31:0] req_xy_1_i;
  logic        apb_psel_o;
  logic        apb_penable_o;
  logic        apb_pwrite_o;
  logic [11:0] apb_paddr_o;
  logic [63:0] apb_pwdata_o;
  logic        apb_pready_i;
  logic        apb_pslverr_i;
  logic        done_o;
  logic        err_o;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  roi_apb_master dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_xy_0_i    (req_xy_0_i),
    .req_xy_1_i    (req_xy_1_i),
    .apb_psel_o    (apb_psel_o),
    .apb_penable_o (apb_penable_o),
    .apb_pwrite_o  (apb_pwrite_o),
    .apb_paddr_o   (apb_paddr_o),
    .apb_pwdata_o  (apb_pwdata_o),
    .apb_pready_i  (apb_pready_i),
    .apb_pslverr_i (apb_pslverr_i),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: completing ACCESS cycles must carry the oldest queued request; done_o retires it.
  always @(negedge clk_i) begin
    if (!arst_i) begin
      if (apb_psel_o && apb_penable_o && apb_pready_i) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_xfer", 64'd1, 64'd0);
        end else begin
          checkOutput("sb_paddr", 64'(apb_paddr_o), 64'(exp_q[0].addr));
          checkOutput("sb_pwdata", apb_pwdata_o, exp_q[0].data);
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_done", 64'd1, 64'd0);
        end else begin
          checkOutput("sb_err", 64'(err_o), 64'(exp_q[0].err));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called just after a rising edge with the DUT idle; walks one full transfer cycle by cycle.
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] xy0,
                               input logic [31:0] xy1, input int waits, input logic slverr);
    exp_t e;
    e.addr = addr; e.data = {xy1, xy0}; e.err = slverr;
    exp_q.push_back(e);
    req_valid_i = 1'b1; req_addr_i = addr; req_xy_0_i = xy0; req_xy_1_i = xy1;
    apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
    @(negedge clk_i);
    checkOutput("c0_ready", 64'(req_ready_o), 64'd1);
    checkOutput("c0_psel", 64'(apb_psel_o), 64'd0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    apb_pready_i = 1'b1; apb_pslverr_i = 1'b1;
    @(negedge clk_i);
    checkOutput("setup_psel", 64'(apb_psel_o), 64'd1);
    checkOutput("setup_penable", 64'(apb_penable_o), 64'd0);
    checkOutput("setup_pwrite", 64'(apb_pwrite_o), 64'd1);
    checkOutput("setup_ready", 64'(req_ready_o), 64'd0);
    checkOutput("setup_pwdata", apb_pwdata_o, {xy1, xy0});
    @(posedge clk_i); #1;
    for (int i = 0; i <= waits; i++) begin
      apb_pready_i  = (i == waits);
      apb_pslverr_i = (i == waits) ? slverr : 1'b1;
      @(negedge clk_i);
      checkOutput("access_psel", 64'(apb_psel_o), 64'd1);
      checkOutput("access_penable", 64'(apb_penable_o), 64'd1);
      checkOutput("access_paddr", 64'(apb_paddr_o), 64'(addr));
      checkOutput("access_pwdata", apb_pwdata_o, {xy1, xy0});
      checkOutput("access_done", 64'(done_o), 64'd0);
      @(posedge clk_i); #1;
    end
    apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
    @(negedge clk_i);
    checkOutput("done_pulse", 64'(done_o), 64'd1);
    checkOutput("done_err", 64'(err_o), 64'(slverr));
    checkOutput("done_psel", 64'(apb_psel_o), 64'd0);
    checkOutput("done_penable", 64'(apb_penable_o), 64'd0);
    checkOutput("done_ready", 64'(req_ready_o), 64'd1);
    checkOutput("done_pwdata_kept", apb_pwdata_o, {xy1, xy0});
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("post_done", 64'(done_o), 64'd0);
    checkOutput("post_err", 64'(err_o), 64'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    exp_t e;
    arst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_xy_0_i = '0; req_xy_1_i = '0;
    apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_ready", 64'(req_ready_o), 64'd1);
    checkOutput("rst_psel", 64'(apb_psel_o), 64'd0);
    checkOutput("rst_penable", 64'(apb_penable_o), 64'd0);
    checkOutput("rst_pwrite", 64'(apb_pwrite_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
    checkOutput("rst_paddr", 64'(apb_paddr_o), 64'd0);
    checkOutput("rst_pwdata", apb_pwdata_o, 64'd0);
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    @(posedge clk_i); #1;

    applyStimulus(12'h000, 32'h0010_0020, 32'h0080_0040, 0, 1'b0);
    applyStimulus(12'h000, 32'h0010_0020, 32'h0080_0040, 3, 1'b0);
    applyStimulus(12'h000, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b1);
    applyStimulus(12'h000, 32'h0001_0002, 32'h0003_0004, 1, 1'b0);
    applyStimulus(12'hFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b1);

    // Back-to-back: valid stays high; second SETUP must begin three cycles after the first.
    e.addr = 12'h000; e.data = 64'h0080_0040_0010_0020; e.err = 1'b0;
    exp_q.push_back(e);
    req_valid_i = 1'b1; req_addr_i = 12'h000; req_xy_0_i = 32'h0010_0020; req_xy_1_i = 32'h0080_0040;
    apb_pready_i = 1'b1; apb_pslverr_i = 1'b0;
    @(posedge clk_i); #1;
    e.addr = 12'h010; e.data = 64'hAAAA_5555_0BAD_F00D; e.err = 1'b0;
    exp_q.push_back(e);
    req_addr_i = 12'h010; req_xy_0_i = 32'h0BAD_F00D; req_xy_1_i = 32'hAAAA_5555;
    @(negedge clk_i);
    checkOutput("b2b_c1_setup", 64'({apb_psel_o, apb_penable_o, req_ready_o}), 64'b100);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("b2b_c2_access", 64'({apb_psel_o, apb_penable_o, req_ready_o}), 64'b110);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("b2b_c3_done", 64'({done_o, apb_psel_o, req_ready_o}), 64'b101);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b2b_c4_setup", 64'({apb_psel_o, apb_penable_o, req_ready_o}), 64'b100);
    checkOutput("b2b_c4_paddr", 64'(apb_paddr_o), 64'h010);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("b2b_c5_access", 64'({apb_psel_o, apb_penable_o}), 64'b11);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("b2b_c6_done", 64'({done_o, err_o, apb_psel_o}), 64'b100);
    @(posedge clk_i); #1;
    apb_pready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b2b_idle", 64'({apb_psel_o, done_o, req_ready_o}), 64'b001);
    @(posedge clk_i); #1;

    // Reset pulse during an ACCESS wait state abandons the transfer.
    e.addr = 12'h000; e.data = 64'h0000_0002_0000_0001; e.err = 1'b0;
    exp_q.push_back(e);
    req_valid_i = 1'b1; req_addr_i = 12'h000; req_xy_0_i = 32'h1; req_xy_1_i = 32'h2;
    apb_pready_i = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    checkOutput("rstmid_pre", 64'({apb_psel_o, apb_penable_o}), 64'b11);
    #2 arst_i = 1'b1;
    #1;
    checkOutput("rstmid_async", 64'({apb_psel_o, apb_penable_o, done_o, req_ready_o}), 64'b0001);
    exp_q.delete();
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("rstmid_after", 64'({apb_psel_o, done_o, req_ready_o}), 64'b001);
      @(posedge clk_i); #1;
    end

    applyStimulus(12'h000, 32'h0010_0020, 32'h0080_0040, 0, 1'b0);

`ifdef ROI_APB_TIMEOUT_EN
    applyStimulus(12'h000, 32'h0000_1111, 32'h0000_2222, 15, 1'b0);
    e.addr = 12'h000; e.data = 64'h0000_0004_0000_0003; e.err = 1'b1;
    exp_q.push_back(e);
    req_valid_i = 1'b1; req_xy_0_i = 32'h3; req_xy_1_i = 32'h4;
    apb_pready_i = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      checkOutput("to_access", 64'({apb_psel_o, apb_penable_o, done_o}), 64'b110);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    checkOutput("to_abort", 64'({done_o, err_o, apb_psel_o, apb_penable_o, req_ready_o}), 64'b11001);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("to_idle", 64'({done_o, err_o, apb_psel_o}), 64'b000);
    @(posedge clk_i); #1;
`endif

    checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
